// File: rtl/vga_vram_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : vga_vram_arbiter                                             |
// | Shares a 256x3 single-port video RAM between the VGA cell prefetch     |
// | and a handshaked CPU writer. Option macro: VRAM_ARB_READBACK_EN adds   |
// | a CPU read port (scan > write > read).                                 |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module vga_vram_arbiter #(
  parameter int MARCO_X = 48,
  parameter int MARCO_Y = 32,
  parameter int CELL_W  = 40,
  parameter int CELL_H  = 30
) (
  input  logic       Clock25,
  input  logic       Reset,
  input  logic [9:0] Cont_X,
  input  logic [9:0] Cont_Y,
  input  logic       iWrReq,
  input  logic [7:0] iWrAddr,
  input  logic [2:0] iWrData,
  output logic       oWrAck,
`ifdef VRAM_ARB_READBACK_EN
  input  logic       iRdReq,
  input  logic [7:0] iRdAddr,
  output logic       oRdAck,
  output logic [2:0] oRdData,
`endif
  output logic [7:0] oRamAddr,
  output logic       oRamWe,
  output logic [2:0] oRamData,
  input  logic [2:0] iRamData,
  output logic [2:0] oColorCell
);

  localparam int c_sub_w = $clog2(CELL_H);

  localparam logic [9:0]         c_y_first     = 10'(MARCO_Y);
  localparam logic [9:0]         c_y_last      = 10'(MARCO_Y + 479);
  localparam logic [9:0]         c_x_win_lo    = 10'(MARCO_X - 1);
  localparam logic [9:0]         c_x_win_hi    = 10'(MARCO_X + 638);
  localparam logic [9:0]         c_x_first_pre = 10'(MARCO_X - 3);
  localparam logic [9:0]         c_x_step      = 10'(CELL_W);
  localparam logic [9:0]         c_x_end       = 10'd799;
  localparam logic [c_sub_w-1:0] c_sub_last    = c_sub_w'(CELL_H - 1);
  localparam logic [c_sub_w-1:0] c_sub_one     = c_sub_w'(1);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_scan = 2'd1;
  localparam logic [1:0] c_st_wr   = 2'd2;
`ifdef VRAM_ARB_READBACK_EN
  localparam logic [1:0] c_st_rd   = 2'd3;
`endif

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [3:0]         r_row;
  logic [c_sub_w-1:0] r_sub;
  logic [9:0]         r_prev_y;
  logic [4:0]         r_col;
  logic [9:0]         r_slot_pre;
  logic               r_fetch;
  logic               w_line_active;
  logic               w_slot_next;
  logic               w_req_block;

  assign w_line_active = (Cont_Y >= c_y_first) && (Cont_Y <= c_y_last);
  // r_slot_pre is the cycle just before the next scan slot of this line
  assign w_slot_next   = w_line_active && !r_col[4] && (Cont_X == r_slot_pre);

`ifdef VRAM_ARB_READBACK_EN
  assign w_req_block = (r_state == c_st_wr) || (r_state == c_st_rd) || oRdAck;
  assign oRdData     = iRamData;
`else
  assign w_req_block = (r_state == c_st_wr);
`endif

  always_comb begin
    w_state_nxt = c_st_idle;
    if (w_slot_next) begin
      w_state_nxt = c_st_scan;
    end else if (!w_req_block && iWrReq) begin
      w_state_nxt = c_st_wr;
`ifdef VRAM_ARB_READBACK_EN
    end else if (!w_req_block && iRdReq) begin
      w_state_nxt = c_st_rd;
`endif
    end
  end

  always_ff @(posedge Clock25) begin
    if (!Reset) begin
      r_state    <= c_st_idle;
      oRamAddr   <= 8'd0;
      oRamWe     <= 1'b0;
      oRamData   <= 3'd0;
      oWrAck     <= 1'b0;
      oColorCell <= 3'd0;
      r_fetch    <= 1'b0;
      r_col      <= 5'd0;
      r_slot_pre <= c_x_first_pre;
      r_row      <= 4'd0;
      r_sub      <= '0;
      r_prev_y   <= 10'd0;
`ifdef VRAM_ARB_READBACK_EN
      oRdAck     <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      oRamWe  <= (w_state_nxt == c_st_wr);
      oWrAck  <= (w_state_nxt == c_st_wr);
      r_fetch <= (r_state == c_st_scan);
`ifdef VRAM_ARB_READBACK_EN
      oRdAck  <= (r_state == c_st_rd);
`endif
      case (w_state_nxt)
        c_st_scan: oRamAddr <= {r_row, r_col[3:0]};
        c_st_wr: begin
          oRamAddr <= iWrAddr;
          oRamData <= iWrData;
        end
`ifdef VRAM_ARB_READBACK_EN
        c_st_rd:   oRamAddr <= iRdAddr;
`endif
        default: ;
      endcase

      if (w_slot_next) begin
        r_col      <= r_col + 5'd1;
        r_slot_pre <= r_slot_pre + c_x_step;
      end
      if (Cont_X == c_x_end) begin
        r_col      <= 5'd0;
        r_slot_pre <= c_x_first_pre;
      end

      // Row tracking follows line changes of Cont_Y instead of dividing it
      r_prev_y <= Cont_Y;
      if (Cont_Y != r_prev_y) begin
        if ((Cont_Y == c_y_first) || (Cont_Y == 10'd0)) begin
          r_row <= 4'd0;
          r_sub <= '0;
        end else if (r_sub == c_sub_last) begin
          r_row <= r_row + 4'd1;
          r_sub <= '0;
        end else begin
          r_sub <= r_sub + c_sub_one;
        end
      end

      // Data of the slot read arrives one cycle after the scan slot
      if (r_fetch) begin
        oColorCell <= iRamData;
      end else if (!w_line_active || (Cont_X < c_x_win_lo) || (Cont_X > c_x_win_hi)) begin
        oColorCell <= 3'd0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_vram_arbiter.sv
`default_nettype none
// Scoreboard bench for vga_vram_arbiter: directed stimulus pushes expected
// RAM grants, scan addresses and cell colours; a monitor pops and compares.
module tb_vga_vram_arbiter;

  typedef struct {
    logic [7:0] addr;
    logic [2:0] data;
    logic [9:0] x;
    logic [9:0] y;
  } wr_t;

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic [7:0] addr;
  } scan_t;

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] color;
  } col_t;

  logic       clk = 1'b0;
  logic       Reset;
  logic [9:0] Cont_X;
  logic [9:0] Cont_Y;
  logic       iWrReq;
  logic [7:0] iWrAddr;
  logic [2:0] iWrData;
  logic       oWrAck;
  logic [7:0] oRamAddr;
  logic       oRamWe;
  logic [2:0] oRamData;
  logic [2:0] iRamData;
  logic [2:0] oColorCell;

  vga_vram_arbiter dut (
    .Clock25   (clk),
    .Reset     (Reset),
    .Cont_X    (Cont_X),
    .Cont_Y    (Cont_Y),
    .iWrReq    (iWrReq),
    .iWrAddr   (iWrAddr),
    .iWrData   (iWrData),
    .oWrAck    (oWrAck),
    .oRamAddr  (oRamAddr),
    .oRamWe    (oRamWe),
    .oRamData  (oRamData),
    .iRamData  (iRamData),
    .oColorCell(oColorCell)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] row2_init(input int c);
    if (c == 3) return 3'b101;
    return 3'((c + 1) % 8);
  endfunction

  // Synchronous single-port RAM model (read-before-write), preloaded on the first edge
  logic [2:0] mem [256];
  logic       loaded = 1'b0;
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 256; i++)
        mem[i] <= (i >= 32 && i < 48) ? row2_init(i - 32) : 3'b000;
      loaded   <= 1'b1;
      iRamData <= 3'b000;
    end else begin
      if (oRamWe === 1'b1) mem[oRamAddr] <= oRamData;
      iRamData <= mem[oRamAddr];
    end
  end

  logic rst_q = 1'b1;
  always @(posedge clk) rst_q <= Reset;

  wr_t   exp_wr[$];
  scan_t exp_scan[$];
  col_t  exp_col[$];
  wr_t   cpu_q[$];

  int   checks = 0;
  int   failures = 0;
  logic end_req = 1'b0;
  logic final_done = 1'b0;
  wr_t   m_w;
  scan_t m_s;
  col_t  m_c;

  always @(negedge clk) begin
    if (rst_q === 1'b0) begin
      checks++;
      if ({oRamWe, oWrAck, oColorCell, oRamAddr, oRamData} !== 16'd0) begin
        failures++;
        $display("FAIL reset_state: we=%b ack=%b color=%b addr=%h data=%b, required all zero",
                 oRamWe, oWrAck, oColorCell, oRamAddr, oRamData);
      end
    end else begin
      if (oWrAck === 1'b1) begin
        checks++;
        if (exp_wr.size() == 0) begin
          failures++;
          $display("FAIL unexpected_ack: ack at X=%0d Y=%0d addr=%h data=%b, required no ack",
                   Cont_X, Cont_Y, oRamAddr, oRamData);
        end else begin
          m_w = exp_wr.pop_front();
          if (oRamWe !== 1'b1 || oRamAddr !== m_w.addr || oRamData !== m_w.data ||
              Cont_X !== m_w.x || Cont_Y !== m_w.y) begin
            failures++;
            $display("FAIL write_grant: we=%b addr=%h data=%b at X=%0d Y=%0d, required we=1 addr=%h data=%b at X=%0d Y=%0d",
                     oRamWe, oRamAddr, oRamData, Cont_X, Cont_Y, m_w.addr, m_w.data, m_w.x, m_w.y);
          end
        end
      end else if (oRamWe !== 1'b0) begin
        checks++;
        failures++;
        $display("FAIL we_without_ack: we=%b at X=%0d Y=%0d, required 0", oRamWe, Cont_X, Cont_Y);
      end

      if (exp_scan.size() > 0 && exp_scan[0].x == Cont_X && exp_scan[0].y == Cont_Y) begin
        m_s = exp_scan.pop_front();
        checks++;
        if (oRamWe !== 1'b0 || oRamAddr !== m_s.addr) begin
          failures++;
          $display("FAIL scan_slot: X=%0d Y=%0d we=%b addr=%h, required we=0 addr=%h",
                   Cont_X, Cont_Y, oRamWe, oRamAddr, m_s.addr);
        end
      end

      if (exp_col.size() > 0 && exp_col[0].x == Cont_X && exp_col[0].y == Cont_Y) begin
        m_c = exp_col.pop_front();
        checks++;
        if (oColorCell !== m_c.color) begin
          failures++;
          $display("FAIL cell_color: X=%0d Y=%0d color=%b, required %b",
                   Cont_X, Cont_Y, oColorCell, m_c.color);
        end
      end
    end

    if (end_req && !final_done) begin
      checks += 4;
      if (exp_wr.size() != 0) begin
        failures++;
        $display("FAIL missing_acks: %0d outstanding, required 0", exp_wr.size());
      end
      if (exp_scan.size() != 0) begin
        failures++;
        $display("FAIL missing_scans: %0d outstanding (next X=%0d Y=%0d), required 0",
                 exp_scan.size(), exp_scan[0].x, exp_scan[0].y);
      end
      if (exp_col.size() != 0) begin
        failures++;
        $display("FAIL missing_colors: %0d outstanding (next X=%0d Y=%0d), required 0",
                 exp_col.size(), exp_col[0].x, exp_col[0].y);
      end
      if (mem[8'h77] !== 3'b000) begin
        failures++;
        $display("FAIL reset_cancel_ram: mem[77]=%b, required 000", mem[8'h77]);
      end
      final_done = 1'b1;
    end
  end

  // One pixel clock: the CPU side drops or replaces its request after an ack
  task automatic step(input logic [9:0] x, input logic [9:0] y);
    logic acked;
    @(negedge clk);
    acked = (oWrAck === 1'b1);
    @(posedge clk);
    #1;
    Cont_X = x;
    Cont_Y = y;
    if (acked) begin
      if (cpu_q.size() > 0) begin
        wr_t r;
        r = cpu_q.pop_front();
        iWrAddr = r.addr;
        iWrData = r.data;
        iWrReq  = 1'b1;
      end else begin
        iWrReq = 1'b0;
      end
    end
  endtask

  task automatic adv(input logic [9:0] y, input logic [9:0] xend);
    while (Cont_X != xend) step(Cont_X + 10'd1, y);
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [2:0] d);
    wr_t r;
    r.addr = a; r.data = d; r.x = 10'd0; r.y = 10'd0;
    if (iWrReq !== 1'b1) begin
      iWrAddr = a;
      iWrData = d;
      iWrReq  = 1'b1;
    end else begin
      cpu_q.push_back(r);
    end
  endtask

  task automatic push_wr(input logic [7:0] a, input logic [2:0] d, input int x, input int y);
    wr_t r;
    r.addr = a; r.data = d; r.x = 10'(x); r.y = 10'(y);
    exp_wr.push_back(r);
  endtask

  task automatic push_scan(input int x, input int y, input logic [7:0] a);
    scan_t s;
    s.x = 10'(x); s.y = 10'(y); s.addr = a;
    exp_scan.push_back(s);
  endtask

  task automatic push_col(input int x, input int y, input logic [2:0] c);
    col_t k;
    k.x = 10'(x); k.y = 10'(y); k.color = c;
    exp_col.push_back(k);
  endtask

  initial begin
    Reset   = 1'b0;
    Cont_X  = 10'd700;
    Cont_Y  = 10'd10;
    iWrReq  = 1'b1;
    iWrAddr = 8'h11;
    iWrData = 3'b110;

    // Reset held with a pending request, then released
    repeat (3) step(10'd700, 10'd10);
    Reset = 1'b1;
    push_wr(8'h11, 3'b110, 701, 10);
    adv(10'd10, 10'd709);

    // Back-to-back requests in blanking: acks every second cycle
    cpu_write(8'h30, 3'b001);
    cpu_write(8'h31, 3'b010);
    cpu_write(8'h5A, 3'b110);
    push_wr(8'h30, 3'b001, 710, 10);
    push_wr(8'h31, 3'b010, 712, 10);
    push_wr(8'h5A, 3'b110, 714, 10);
    adv(10'd10, 10'd720);

    // Walk lines down to row 2 through the top margin
    for (int y = 11; y <= 91; y++) step(10'd720, 10'(y));
    adv(10'd91, 10'd799);

    // Line 92 (row 2): all 16 scan slots and the resulting cell colours
    for (int c = 0; c < 16; c++) push_scan(46 + 40 * c, 92, {4'd2, 4'(c)});
    push_col(47, 92, 3'b000);
    for (int c = 0; c < 16; c++) begin
      if (c == 3) begin
        for (int x = 168; x <= 207; x++) push_col(x, 92, 3'b101);
      end else begin
        push_col(48 + 40 * c, 92, row2_init(c));
        push_col(87 + 40 * c, 92, row2_init(c));
      end
    end
    push_col(688, 92, 3'b000);
    step(10'd0, 10'd92);

    // Request at X=85 collides with the X=86 slot
    adv(10'd92, 10'd85);
    cpu_write(8'h40, 3'b011);
    push_wr(8'h40, 3'b011, 87, 92);

    // Overwrite an already prefetched cell; visible only on the next line
    adv(10'd92, 10'd300);
    cpu_write(8'h21, 3'b110);
    push_wr(8'h21, 3'b110, 301, 92);

    push_scan(46, 93, 8'h20);
    push_scan(86, 93, 8'h21);
    push_col(48, 93, row2_init(0));
    push_col(88, 93, 3'b110);
    push_col(127, 93, 3'b110);
    push_col(128, 93, row2_init(2));
    adv(10'd92, 10'd799);
    step(10'd0, 10'd93);
    adv(10'd93, 10'd719);

    // Reset asserted in the cycle the grant would be decided
    step(10'd720, 10'd93);
    Reset = 1'b0;
    cpu_write(8'h77, 3'b101);
    step(10'd721, 10'd93);
    Reset  = 1'b1;
    iWrReq = 1'b0;
    adv(10'd93, 10'd730);

    end_req = 1'b1;
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
